// File: rtl/auto_nav_pkg.sv
// rtl/auto_nav_pkg.sv - shared types and constants for the autonomous navigation planner
package auto_nav_pkg;

  localparam int TICK_HZ               = 500;
  localparam int CYCLE_TIME_US         = 1_000_000 / TICK_HZ;
  localparam int DEFAULT_SETTLE_CYCLES = 10;
  localparam int DEFAULT_ESCAPE_CYCLES = 250;
  localparam int DEFAULT_ACK_TIMEOUT   = 4;

  // Bit positions inside the packed detector pattern {front, left, right}
  localparam int DET_FRONT = 2;
  localparam int DET_LEFT  = 1;
  localparam int DET_RIGHT = 0;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FORWARD   = 3'd1,
    ST_DECIDE    = 3'd2,
    ST_ISSUE     = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_ESCAPE    = 3'd5,
    ST_FAULT     = 3'd6
  } nav_state_e;

  typedef enum logic [1:0] {
    LEFT  = 2'd0,
    RIGHT = 2'd1,
    BACK  = 2'd2
  } turn_choice_e;

endpackage

// File: rtl/detector_debounce.sv
// rtl/detector_debounce.sv - 2-flop synchroniser and shared stable-pattern debouncer
module detector_debounce #(
  parameter int SETTLE_CYCLES = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] det_raw,
  output logic [2:0] det_stable
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);

  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [CW-1:0] cnt;

  // sync1 != sync2 means sync2 is about to change, so the run restarts on that edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= '0;
      sync2      <= '0;
      cnt        <= '0;
      det_stable <= '0;
    end else begin
      sync1 <= det_raw;
      sync2 <= sync1;
      if (sync1 != sync2)
        cnt <= '0;
      else if (cnt != CW'(SETTLE_CYCLES))
        cnt <= cnt + CW'(1);
      if ((sync1 == sync2) && (cnt >= CW'(SETTLE_CYCLES - 1)))
        det_stable <= sync2;
    end
  end

endmodule

// File: rtl/auto_nav_planner.sv
// rtl/auto_nav_planner.sv - obstacle-driven turn planner feeding the auto_turning executor
module auto_nav_planner
  import auto_nav_pkg::*;
#(
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
  parameter int ESCAPE_CYCLES = DEFAULT_ESCAPE_CYCLES,
  parameter int ACK_TIMEOUT   = DEFAULT_ACK_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       detect_front,
  input  logic       detect_left,
  input  logic       detect_right,
  input  logic       is_turning,
  output logic       trigger_turn_left,
  output logic       trigger_turn_right,
  output logic       trigger_turn_back,
  output logic       move_forward,
  output logic       brake,
  output logic [2:0] state_o
);

  localparam int AW = $clog2(ACK_TIMEOUT + 1);
  localparam int EW = $clog2(ESCAPE_CYCLES + 1);

  nav_state_e    state_q, state_d;
  turn_choice_e  choice_q, choice_d;
  logic [AW-1:0] ack_cnt_q, ack_cnt_d;
  logic [EW-1:0] esc_cnt_q, esc_cnt_d;
  logic [2:0]    det_stable;
  logic          tl_d, tr_d, tb_d, mf_d, br_d;

  detector_debounce #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_debounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .det_raw    ({detect_front, detect_left, detect_right}),
    .det_stable (det_stable)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= ST_IDLE;
      choice_q           <= LEFT;
      ack_cnt_q          <= '0;
      esc_cnt_q          <= '0;
      trigger_turn_left  <= 1'b0;
      trigger_turn_right <= 1'b0;
      trigger_turn_back  <= 1'b0;
      move_forward       <= 1'b0;
      brake              <= 1'b1;
    end else begin
      state_q            <= state_d;
      choice_q           <= choice_d;
      ack_cnt_q          <= ack_cnt_d;
      esc_cnt_q          <= esc_cnt_d;
      trigger_turn_left  <= tl_d;
      trigger_turn_right <= tr_d;
      trigger_turn_back  <= tb_d;
      move_forward       <= mf_d;
      brake              <= br_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    choice_d  = choice_q;
    ack_cnt_d = ack_cnt_q;
    esc_cnt_d = esc_cnt_q;
    if (!enable) begin
      state_d   = ST_IDLE;
      ack_cnt_d = '0;
      esc_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE:    state_d = ST_FORWARD;
        ST_FORWARD: if (det_stable[DET_FRONT]) state_d = ST_DECIDE;
        ST_DECIDE: begin
          if (!det_stable[DET_LEFT])       choice_d = LEFT;
          else if (!det_stable[DET_RIGHT]) choice_d = RIGHT;
          else                             choice_d = BACK;
          ack_cnt_d = '0;
          state_d   = ST_ISSUE;
        end
        ST_ISSUE: begin
          if (is_turning)                            state_d = ST_WAIT_DONE;
          else if (ack_cnt_q >= AW'(ACK_TIMEOUT - 1)) state_d = ST_FAULT;
          else                                       ack_cnt_d = ack_cnt_q + AW'(1);
        end
        ST_WAIT_DONE: begin
          if (!is_turning) begin
            state_d   = ST_ESCAPE;
            esc_cnt_d = '0;
          end
        end
        ST_ESCAPE: begin
          if (esc_cnt_q >= EW'(ESCAPE_CYCLES - 1)) state_d = ST_FORWARD;
          else                                     esc_cnt_d = esc_cnt_q + EW'(1);
        end
        ST_FAULT: state_d = ST_FAULT;
        default:  state_d = ST_IDLE;
      endcase
    end

    // Outputs are decoded from the next state so they register in step with it
    tl_d = (state_d == ST_ISSUE) && (choice_d == LEFT);
    tr_d = (state_d == ST_ISSUE) && (choice_d == RIGHT);
    tb_d = (state_d == ST_ISSUE) && (choice_d == BACK);
    mf_d = (state_d == ST_FORWARD) || (state_d == ST_ESCAPE);
    br_d = (state_d == ST_IDLE) || (state_d == ST_DECIDE) ||
           (state_d == ST_ISSUE) || (state_d == ST_FAULT);
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_auto_nav_planner.sv
// tb/tb_auto_nav_planner.sv - directed self-checking bench for auto_nav_planner
module tb_auto_nav_planner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       detect_front, detect_left, detect_right;
  logic       is_turning;
  logic       trigger_turn_left, trigger_turn_right, trigger_turn_back;
  logic       move_forward, brake;
  logic [2:0] state_o;
  logic [2:0] trig;
  int         checks = 0;
  int         errors = 0;

  assign trig = {trigger_turn_left, trigger_turn_right, trigger_turn_back};

  always #5 clk = ~clk;

  auto_nav_planner dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .enable             (enable),
    .detect_front       (detect_front),
    .detect_left        (detect_left),
    .detect_right       (detect_right),
    .is_turning         (is_turning),
    .trigger_turn_left  (trigger_turn_left),
    .trigger_turn_right (trigger_turn_right),
    .trigger_turn_back  (trigger_turn_back),
    .move_forward       (move_forward),
    .brake              (brake),
    .state_o            (state_o)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_det(input logic f, input logic l, input logic r);
    detect_front = f;
    detect_left  = l;
    detect_right = r;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; enable = 1'b0; is_turning = 1'b0;
    set_det(1'b0, 1'b0, 1'b0);
    step(2);
    checks++;
    if ({trig, move_forward, brake, state_o} !== {3'b000, 1'b0, 1'b1, 3'd0}) begin
      errors++;
      $display("FAIL reset_outputs: got trig=%b mf=%b brake=%b state=%0d, want trig=000 mf=0 brake=1 state=0",
               trig, move_forward, brake, state_o);
    end
    rst_n = 1'b1;
    step(3);
    checks++;
    if (state_o !== 3'd0 || brake !== 1'b1) begin
      errors++;
      $display("FAIL idle_while_disabled: got state=%0d brake=%b, want 0 1", state_o, brake);
    end
  endtask

  task automatic test_left_turn;
    int esc;
    enable = 1'b1;
    step(1);
    checks++;
    if (state_o !== 3'd1 || move_forward !== 1'b1 || brake !== 1'b0) begin
      errors++;
      $display("FAIL enter_forward: got state=%0d mf=%b brake=%b, want 1 1 0", state_o, move_forward, brake);
    end
    set_det(1'b1, 1'b0, 1'b0);
    step(13);
    checks++;
    if (state_o !== 3'd2 || brake !== 1'b1 || trig !== 3'b000) begin
      errors++;
      $display("FAIL decide_timing: got state=%0d brake=%b trig=%b, want 2 1 000", state_o, brake, trig);
    end
    step(1);
    checks++;
    if (state_o !== 3'd3 || trig !== 3'b100 || brake !== 1'b1) begin
      errors++;
      $display("FAIL left_trigger: got state=%0d trig=%b brake=%b, want 3 100 1", state_o, trig, brake);
    end
    step(1);
    checks++;
    if (trig !== 3'b100) begin
      errors++;
      $display("FAIL left_trigger_hold: got trig=%b, want 100", trig);
    end
    is_turning = 1'b1;
    step(1);
    checks++;
    if (state_o !== 3'd4 || trig !== 3'b000 || move_forward !== 1'b0 || brake !== 1'b0) begin
      errors++;
      $display("FAIL wait_done_entry: got state=%0d trig=%b mf=%b brake=%b, want 4 000 0 0",
               state_o, trig, move_forward, brake);
    end
    set_det(1'b0, 1'b0, 1'b0);
    step(3);
    checks++;
    if (state_o !== 3'd4) begin
      errors++;
      $display("FAIL wait_done_hold: got state=%0d, want 4", state_o);
    end
    is_turning = 1'b0;
    step(1);
    esc = (state_o == 3'd5 && move_forward == 1'b1) ? 1 : 0;
    for (int i = 0; i < 300; i++) begin
      if (i == 100) is_turning = 1'b1;
      if (i == 101) is_turning = 1'b0;
      step(1);
      if (state_o == 3'd5 && move_forward == 1'b1) esc++;
      else break;
    end
    checks++;
    if (esc !== 250) begin
      errors++;
      $display("FAIL escape_length: got %0d cycles, want 250", esc);
    end
    checks++;
    if (state_o !== 3'd1 || move_forward !== 1'b1) begin
      errors++;
      $display("FAIL escape_to_forward: got state=%0d mf=%b, want 1 1", state_o, move_forward);
    end
    is_turning = 1'b1;
    step(1);
    is_turning = 1'b0;
    step(1);
    checks++;
    if (state_o !== 3'd1 || trig !== 3'b000) begin
      errors++;
      $display("FAIL spurious_busy_forward: got state=%0d trig=%b, want 1 000", state_o, trig);
    end
  endtask

  task automatic test_right_back;
    set_det(1'b1, 1'b1, 1'b0);
    step(14);
    checks++;
    if (state_o !== 3'd3 || trig !== 3'b010) begin
      errors++;
      $display("FAIL right_trigger: got state=%0d trig=%b, want 3 010", state_o, trig);
    end
    is_turning = 1'b1;
    step(1);
    set_det(1'b1, 1'b1, 1'b1);
    is_turning = 1'b0;
    step(1);
    step(249);
    checks++;
    if (state_o !== 3'd5) begin
      errors++;
      $display("FAIL escape_last_cycle: got state=%0d, want 5", state_o);
    end
    step(1);
    checks++;
    if (state_o !== 3'd1) begin
      errors++;
      $display("FAIL escape_exit: got state=%0d, want 1", state_o);
    end
    is_turning = 1'b1;
    step(1);
    checks++;
    if (state_o !== 3'd2) begin
      errors++;
      $display("FAIL redecide_after_escape: got state=%0d, want 2", state_o);
    end
    step(1);
    checks++;
    if (state_o !== 3'd3 || trig !== 3'b001) begin
      errors++;
      $display("FAIL back_trigger: got state=%0d trig=%b, want 3 001", state_o, trig);
    end
    step(1);
    checks++;
    if (state_o !== 3'd4 || trig !== 3'b000) begin
      errors++;
      $display("FAIL busy_early_one_cycle: got state=%0d trig=%b, want 4 000", state_o, trig);
    end
    enable = 1'b0;
    step(1);
    checks++;
    if (state_o !== 3'd0 || brake !== 1'b1 || move_forward !== 1'b0 || trig !== 3'b000) begin
      errors++;
      $display("FAIL disable_in_wait_done: got state=%0d brake=%b mf=%b trig=%b, want 0 1 0 000",
               state_o, brake, move_forward, trig);
    end
    set_det(1'b0, 1'b0, 1'b0);
    is_turning = 1'b0;
    step(14);
    enable = 1'b1;
    step(1);
    checks++;
    if (state_o !== 3'd1) begin
      errors++;
      $display("FAIL reenable_forward: got state=%0d, want 1", state_o);
    end
  endtask

  task automatic test_bounce_timeout;
    int bad;
    int hi;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      if (i % 5 == 0) detect_front = ~detect_front;
      step(1);
      if (trig !== 3'b000 || move_forward !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL bounce_ignored: got %0d bad cycles, want 0", bad);
    end
    detect_front = 1'b1;
    step(13);
    checks++;
    if (state_o !== 3'd2 || trig !== 3'b000) begin
      errors++;
      $display("FAIL bounce_settle_decide: got state=%0d trig=%b, want 2 000", state_o, trig);
    end
    step(1);
    hi = (trig == 3'b100) ? 1 : 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (trig == 3'b100) hi++;
      else break;
    end
    checks++;
    if (hi !== 4) begin
      errors++;
      $display("FAIL ack_timeout_hold: got %0d cycles, want 4", hi);
    end
    step(2);
    checks++;
    if (state_o !== 3'd6 || brake !== 1'b1 || trig !== 3'b000 || move_forward !== 1'b0) begin
      errors++;
      $display("FAIL fault_state: got state=%0d brake=%b trig=%b mf=%b, want 6 1 000 0",
               state_o, brake, trig, move_forward);
    end
    enable = 1'b0;
    step(1);
    checks++;
    if (state_o !== 3'd0) begin
      errors++;
      $display("FAIL fault_clear_idle: got state=%0d, want 0", state_o);
    end
    enable = 1'b1;
    step(1);
    checks++;
    if (state_o !== 3'd1) begin
      errors++;
      $display("FAIL fault_clear_forward: got state=%0d, want 1", state_o);
    end
  endtask

  task automatic test_reset_mid_turn;
    step(2);
    checks++;
    if (state_o !== 3'd3 || trig !== 3'b100) begin
      errors++;
      $display("FAIL issue_before_reset: got state=%0d trig=%b, want 3 100", state_o, trig);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (trig !== 3'b000 || brake !== 1'b1 || move_forward !== 1'b0 || state_o !== 3'd0) begin
      errors++;
      $display("FAIL async_reset: got trig=%b brake=%b mf=%b state=%0d, want 000 1 0 0",
               trig, brake, move_forward, state_o);
    end
    #1 rst_n = 1'b1;
    step(1);
    checks++;
    if (state_o !== 3'd1) begin
      errors++;
      $display("FAIL after_reset_forward: got state=%0d, want 1", state_o);
    end
  endtask

  initial begin
    test_reset();
    test_left_turn();
    test_right_back();
    test_bounce_timeout();
    test_reset_mid_turn();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
